move_sequencer: RTL and testbench
=================================

MOVE_SEQUENCER -- requirements
Module: move_sequencer

Interface
REQ-001 The parameter list SHALL be: COLS, default 7, number of board columns.
REQ-002 The parameter list SHALL continue: ROWS, default 6, number of board rows.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port game_active, input, 1 bit: requests are accepted only while this is high.
REQ-006 Port clear, input, 1 bit: synchronous new-game clear.
REQ-007 Port current_player, input, 1 bit: 0 = FPGA player, 1 = Arduino player.
REQ-008 Port req_fpga and port col_fpga, inputs, 1 and 3 bits: FPGA move strobe and column.
REQ-009 Port req_ard and port col_ard, inputs, 1 and 3 bits: Arduino move strobe and column.
REQ-010 Ports wr_en, wr_col and wr_row, outputs, 1, 3 and 3 bits: board cell write command.
REQ-011 Port wr_val, output, 2 bits: piece code, 01 = FPGA, 10 = Arduino.
REQ-012 Ports move_done, move_reject and out_of_turn, outputs, 1 bit each: one-cycle status pulses.
REQ-013 Port busy, output, 1 bit: high while not in IDLE.
REQ-014 Ports pieces and board_full, outputs, 6 and 1 bits: placed-piece count and count == COLS*ROWS.

Function
REQ-015 The state machine SHALL have the states IDLE, CHECK, WRITE, DONE and REJECT.
REQ-016 Arbitration in IDLE with game_active=1 and board_full=0:
- only the strobe of the player selected by current_player is accepted;
- its column is latched into col_q, and the player is latched into plr_q;
- next state is CHECK.
REQ-017 A strobe from the non-current player in IDLE SHALL pulse out_of_turn the next cycle, cause no state change, and is never queued.
REQ-018 If both strobes are high in the same cycle, only the current player's strobe is served, and out_of_turn also pulses.
REQ-019 In CHECK, the next state SHALL be:
- REJECT if col_q >= COLS or height[col_q] == ROWS;
- otherwise WRITE.
REQ-020 In WRITE, the block SHALL, for exactly one cycle:
- drive wr_en=1, wr_col=col_q, wr_row=height[col_q] (row 0 = bottom), wr_val per plr_q;
- increment height[col_q] and pieces.
REQ-021 In DONE, move_done SHALL pulse for one cycle, then the state returns to IDLE.
REQ-022 In REJECT, move_reject SHALL pulse for one cycle, then the state returns to IDLE; heights and pieces are unchanged.
REQ-023 Latency: a strobe accepted in cycle t SHALL give wr_en in t+2 and move_done in t+3; a rejected strobe gives move_reject in t+2.
REQ-024 Strobes arriving while busy=1 SHALL be ignored without any pulse.
REQ-025 When wr_en=0, wr_col, wr_row and wr_val SHALL be 0.
REQ-026 Per-column height counters SHALL saturate at ROWS, and pieces SHALL saturate at COLS*ROWS.
REQ-027 When game_active or board_full is low/high respectively mid-move (after acceptance), the in-flight move SHALL complete normally.
REQ-028 clear SHALL zero all heights and pieces and force IDLE; it takes priority over every other event in the same cycle.

Reset
REQ-029 While rst=0, the block SHALL hold:
- state IDLE;
- all heights, pieces, col_q and plr_q at 0;
- every output at 0.
REQ-030 Reset assertion mid-move SHALL abort the move with no write and no pulse.

Structure
REQ-031 A shared package SHALL hold:
- the state enumeration;
- piece codes PIECE_EMPTY=00, PIECE_FPGA=01, PIECE_ARD=10;
- the COLS/ROWS defaults.
REQ-032 One sub-module, column_height, SHALL implement the saturating per-column counter, instantiated COLS times.

Verification
REQ-033 Reset then FPGA req col 3 -> wr_en at t+2 with col 3, row 0, val 01; move_done at t+3; pieces=1.
REQ-034 Six accepted moves into col 2, then a seventh -> rows 0..5 written; move_reject at t+2 of the seventh; pieces unchanged.
REQ-035 current_player=1 with req_fpga col 1 -> out_of_turn pulse, no wr_en, busy stays 0.
REQ-036 col 7 requested -> move_reject, no write.
REQ-037 Fill 42 cells -> board_full=1; the next valid strobe gives no response.
REQ-038 rst asserted low during CHECK -> no wr_en and no move_done; all outputs 0 immediately.

Source files
------------

// File: rtl/move_sequencer_pkg.sv
// Shared types and constants for the move sequencer: FSM states, piece codes and
// default board dimensions.
package move_sequencer_pkg;

    localparam int unsigned DEF_COLS = 7;
    localparam int unsigned DEF_ROWS = 6;

    localparam logic [1:0] PIECE_EMPTY = 2'b00;
    localparam logic [1:0] PIECE_FPGA  = 2'b01;
    localparam logic [1:0] PIECE_ARD   = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StWrite,
        StDone,
        StReject
    } state_e;

    function automatic logic [1:0] piece_code(input logic plr);
        return plr ? PIECE_ARD : PIECE_FPGA;
    endfunction

endpackage

// File: rtl/column_height.sv
// Saturating fill-height counter for one board column; row 0 is the bottom.
module column_height
    import move_sequencer_pkg::*;
#(
    parameter int unsigned ROWS = DEF_ROWS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       inc,
    output logic [2:0] height,
    output logic       full
);

    logic [2:0] height_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            height_q <= '0;
        end else if (clear) begin
            height_q <= '0;
        end else if (inc && !full) begin
            height_q <= height_q + 3'd1;
        end
    end

    assign height = height_q;
    assign full   = (height_q == 3'(ROWS));

endmodule

// File: rtl/move_sequencer.sv
// Arbitrates move requests from the two players, validates the column and issues a
// single board-cell write per accepted move, with done/reject/out-of-turn pulses.
module move_sequencer
    import move_sequencer_pkg::*;
#(
    parameter int unsigned COLS = DEF_COLS,
    parameter int unsigned ROWS = DEF_ROWS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       game_active,
    input  logic       clear,
    input  logic       current_player,
    input  logic       req_fpga,
    input  logic [2:0] col_fpga,
    input  logic       req_ard,
    input  logic [2:0] col_ard,
    output logic       wr_en,
    output logic [2:0] wr_col,
    output logic [2:0] wr_row,
    output logic [1:0] wr_val,
    output logic       move_done,
    output logic       move_reject,
    output logic       out_of_turn,
    output logic       busy,
    output logic [5:0] pieces,
    output logic       board_full
);

    localparam logic [5:0] TOTAL = 6'(COLS * ROWS);

    state_e     state_q, state_d;
    logic [2:0] col_q, col_d;
    logic       plr_q, plr_d;
    logic       oot_q, oot_d;
    logic [5:0] pieces_q;

    logic [2:0]      height [COLS];
    logic [COLS-1:0] col_full;
    logic [2:0]      cur_height;
    logic            cur_full;
    logic            col_oob;
    logic            do_write;
    logic            own_req;
    logic            other_req;

    assign do_write = (state_q == StWrite);

    for (genvar g = 0; g < COLS; g++) begin : g_col
        column_height #(
            .ROWS(ROWS)
        ) u_column_height (
            .clk   (clk),
            .rst   (rst),
            .clear (clear),
            .inc   (do_write && (col_q == 3'(g))),
            .height(height[g]),
            .full  (col_full[g])
        );
    end

    // Mux by compare so an out-of-range col_q never indexes past the array.
    always_comb begin
        cur_height = '0;
        cur_full   = 1'b0;
        for (int i = 0; i < COLS; i++) begin
            if (col_q == 3'(i)) begin
                cur_height = height[i];
                cur_full   = col_full[i];
            end
        end
    end

    assign col_oob   = (32'(col_q) >= COLS);
    assign own_req   = current_player ? req_ard : req_fpga;
    assign other_req = current_player ? req_fpga : req_ard;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            col_q   <= '0;
            plr_q   <= 1'b0;
            oot_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            plr_q   <= plr_d;
            oot_q   <= oot_d;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        plr_d   = plr_q;
        oot_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (game_active && !board_full) begin
                    oot_d = other_req;
                    if (own_req) begin
                        state_d = StCheck;
                        col_d   = current_player ? col_ard : col_fpga;
                        plr_d   = current_player;
                    end
                end
            end
            StCheck:  state_d = (col_oob || cur_full) ? StReject : StWrite;
            StWrite:  state_d = StDone;
            StDone:   state_d = StIdle;
            StReject: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        if (clear) begin
            state_d = StIdle;
            oot_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pieces_q <= '0;
        end else if (clear) begin
            pieces_q <= '0;
        end else if (do_write && (pieces_q != TOTAL)) begin
            pieces_q <= pieces_q + 6'd1;
        end
    end

    assign wr_en       = do_write;
    assign wr_col      = do_write ? col_q : 3'd0;
    assign wr_row      = do_write ? cur_height : 3'd0;
    assign wr_val      = do_write ? piece_code(plr_q) : PIECE_EMPTY;
    assign move_done   = (state_q == StDone);
    assign move_reject = (state_q == StReject);
    assign out_of_turn = oot_q;
    assign busy        = (state_q != StIdle);
    assign pieces      = pieces_q;
    assign board_full  = (pieces_q == TOTAL);

endmodule

// File: tb/tb_move_sequencer.sv
// Self-checking bench for move_sequencer: directed scenarios plus randomized requests
// compared against a board-level reference model.
module tb_move_sequencer;

    localparam int COLS  = 7;
    localparam int ROWS  = 6;
    localparam int TOTAL = COLS * ROWS;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       game_active = 1'b0;
    logic       clear = 1'b0;
    logic       current_player = 1'b0;
    logic       req_fpga = 1'b0;
    logic [2:0] col_fpga = 3'd0;
    logic       req_ard = 1'b0;
    logic [2:0] col_ard = 3'd0;
    logic       wr_en;
    logic [2:0] wr_col;
    logic [2:0] wr_row;
    logic [1:0] wr_val;
    logic       move_done;
    logic       move_reject;
    logic       out_of_turn;
    logic       busy;
    logic [5:0] pieces;
    logic       board_full;

    int checks = 0;
    int errors = 0;

    // Reference board: fill height per column and total placed pieces.
    int h [8];
    int npieces;

    always #5 clk = ~clk;

    move_sequencer #(
        .COLS(COLS),
        .ROWS(ROWS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .game_active   (game_active),
        .clear         (clear),
        .current_player(current_player),
        .req_fpga      (req_fpga),
        .col_fpga      (col_fpga),
        .req_ard       (req_ard),
        .col_ard       (col_ard),
        .wr_en         (wr_en),
        .wr_col        (wr_col),
        .wr_row        (wr_row),
        .wr_val        (wr_val),
        .move_done     (move_done),
        .move_reject   (move_reject),
        .out_of_turn   (out_of_turn),
        .busy          (busy),
        .pieces        (pieces),
        .board_full    (board_full)
    );

    // {wr_en, wr_col, wr_row, wr_val, move_done, move_reject, out_of_turn, busy}
    function automatic logic [12:0] obs();
        return {wr_en, wr_col, wr_row, wr_val, move_done, move_reject, out_of_turn, busy};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) h[i] = 0;
        npieces = 0;
    endtask

    // Starts at a falling edge; presents one request cycle and checks the four
    // following cycles plus the piece count against the model.
    task automatic test_move(input string name, input logic ga, input logic ga_after,
                             input logic cp, input logic rf, input logic [2:0] cf,
                             input logic ra, input logic [2:0] ca);
        logic        own, other, acc, ok;
        logic [2:0]  col;
        int          row;
        logic [12:0] exp [1:4];
        own   = cp ? ra : rf;
        other = cp ? rf : ra;
        acc   = ga && (npieces < TOTAL) && own;
        col   = cp ? ca : cf;
        ok    = acc && (int'(col) < COLS) && (h[col] < ROWS);
        row   = ok ? h[col] : 0;
        exp[1] = {9'b0, 1'b0, 1'b0, ga && (npieces < TOTAL) && other, acc};
        exp[2] = {ok, ok ? col : 3'd0, 3'(row), ok ? (cp ? 2'b10 : 2'b01) : 2'b00,
                  1'b0, acc && !ok, 1'b0, acc};
        exp[3] = {9'b0, ok, 1'b0, 1'b0, ok};
        exp[4] = '0;
        if (ok) begin
            h[col]++;
            npieces++;
        end
        game_active    = ga;
        current_player = cp;
        req_fpga       = rf;
        col_fpga       = cf;
        req_ard        = ra;
        col_ard        = ca;
        @(posedge clk);
        #1;
        req_fpga    = 1'b0;
        req_ard     = 1'b0;
        game_active = ga_after;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++;
            if (obs() !== exp[k]) begin
                errors++;
                $display("FAIL %s t+%0d outputs: got %b expected %b", name, k, obs(), exp[k]);
            end
        end
        checks++;
        if (pieces !== 6'(npieces) || board_full !== (npieces == TOTAL)) begin
            errors++;
            $display("FAIL %s count: got pieces=%0d full=%b expected pieces=%0d full=%b",
                     name, pieces, board_full, npieces, npieces == TOTAL);
        end
    endtask

    task automatic test_reset();
        game_active = 1'b1;
        req_fpga    = 1'b1;
        col_fpga    = 3'd3;
        repeat (2) @(negedge clk);
        checks++;
        if (obs() !== 13'b0 || pieces !== 6'd0 || board_full !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: got %b pieces=%0d full=%b expected all zero",
                     obs(), pieces, board_full);
        end
        req_fpga = 1'b0;
        rst      = 1'b1;
        model_reset();
        @(negedge clk);
        checks++;
        if (obs() !== 13'b0) begin
            errors++;
            $display("FAIL reset_release: got %b expected 0", obs());
        end
    endtask

    task automatic test_single_move();
        test_move("single_col3", 1'b1, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 3'd0);
    endtask

    task automatic test_column_fill();
        for (int i = 0; i < 7; i++) begin
            logic p;
            p = 1'(i % 2);
            test_move($sformatf("col2_fill_%0d", i), 1'b1, 1'b1, p, !p, 3'd2, p, 3'd2);
        end
    endtask

    task automatic test_out_of_turn();
        test_move("oot_fpga", 1'b1, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0, 3'd0);
        test_move("oot_ard", 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 3'd4);
        test_move("both_strobes", 1'b1, 1'b1, 1'b1, 1'b1, 3'd5, 1'b1, 3'd6);
        test_move("inactive", 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 3'd0);
    endtask

    task automatic test_bad_column();
        test_move("col7", 1'b1, 1'b1, 1'b0, 1'b1, 3'd7, 1'b0, 3'd0);
        test_move("col7_ard", 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 3'd7);
    endtask

    task automatic test_clear();
        game_active    = 1'b1;
        current_player = 1'b0;
        req_fpga       = 1'b1;
        col_fpga       = 3'd1;
        req_ard        = 1'b1;
        clear          = 1'b1;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        req_fpga = 1'b0;
        req_ard  = 1'b0;
        model_reset();
        @(negedge clk);
        checks++;
        if (obs() !== 13'b0 || pieces !== 6'd0 || board_full !== 1'b0) begin
            errors++;
            $display("FAIL clear: got %b pieces=%0d full=%b expected all zero",
                     obs(), pieces, board_full);
        end
    endtask

    // Strobes held from both players throughout a move must be ignored while busy.
    task automatic test_busy_ignore();
        logic [12:0] exp [1:4];
        int row;
        row = h[0];
        exp[1] = {9'b0, 4'b0001};
        exp[2] = {1'b1, 3'd0, 3'(row), 2'b01, 4'b0001};
        exp[3] = {9'b0, 4'b1001};
        exp[4] = '0;
        h[0]++;
        npieces++;
        game_active    = 1'b1;
        current_player = 1'b0;
        req_fpga       = 1'b1;
        col_fpga       = 3'd0;
        req_ard        = 1'b0;
        @(posedge clk);
        #1;
        req_ard = 1'b1;
        col_ard = 3'd4;
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) begin
                @(posedge clk);
                #1;
                req_fpga = 1'b0;
                req_ard  = 1'b0;
            end
            @(negedge clk);
            checks++;
            if (obs() !== exp[k]) begin
                errors++;
                $display("FAIL busy_ignore t+%0d: got %b expected %b", k, obs(), exp[k]);
            end
        end
        checks++;
        if (pieces !== 6'(npieces)) begin
            errors++;
            $display("FAIL busy_ignore count: got %0d expected %0d", pieces, npieces);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            logic ga, ga_after, cp, rf, ra;
            logic [2:0] cf, ca;
            ga       = ($urandom_range(0, 9) != 0);
            ga_after = 1'($urandom_range(0, 1));
            cp       = 1'($urandom_range(0, 1));
            rf       = ($urandom_range(0, 3) != 0);
            ra       = ($urandom_range(0, 3) != 0);
            cf       = 3'($urandom_range(0, 7));
            ca       = 3'($urandom_range(0, 7));
            test_move($sformatf("rand_%0d", i), ga, ga_after, cp, rf, cf, ra, ca);
        end
    endtask

    task automatic test_full_board();
        test_clear();
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                logic p;
                p = 1'($urandom_range(0, 1));
                test_move($sformatf("fill_c%0d_r%0d", c, r), 1'b1, 1'b1, p, !p, 3'(c),
                          p, 3'(c));
            end
        end
        checks++;
        if (board_full !== 1'b1 || pieces !== 6'(TOTAL)) begin
            errors++;
            $display("FAIL full_flag: got full=%b pieces=%0d expected 1 and %0d",
                     board_full, pieces, TOTAL);
        end
        test_move("after_full", 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 3'd0);
    endtask

    task automatic test_reset_mid_move();
        test_clear();
        test_move("pre_reset", 1'b1, 1'b1, 1'b0, 1'b1, 3'd5, 1'b0, 3'd0);
        game_active    = 1'b1;
        current_player = 1'b1;
        req_ard        = 1'b1;
        col_ard        = 3'd3;
        @(posedge clk);
        #1;
        req_ard = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_move_busy: got %b expected 1", busy);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (obs() !== 13'b0 || pieces !== 6'd0 || board_full !== 1'b0) begin
            errors++;
            $display("FAIL reset_immediate: got %b pieces=%0d expected all zero", obs(), pieces);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (obs() !== 13'b0) begin
                errors++;
                $display("FAIL reset_hold_%0d: got %b expected 0", k, obs());
            end
        end
        rst = 1'b1;
        model_reset();
        test_move("post_reset", 1'b1, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 3'd0);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_move();
        test_column_fill();
        test_out_of_turn();
        test_bad_column();
        test_clear();
        test_busy_ignore();
        test_random();
        test_full_board();
        test_reset_mid_move();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule
